// File: rtl/multi_pluse_sync_rx_pkg.sv
// ----------------------------------------------------------------------------
// multi_pluse_sync_pkg
// Shared definitions for the multi-channel pulse synchronizer receive side.
//   MODE_TOGGLE / MODE_HSK : protocol selectors (2-phase toggle, 4-phase req/ack)
//   ch_state_t             : per-channel handshake state encoding
//   sync_stg_ok()          : elaboration-time sanity check for the sync depth
// ----------------------------------------------------------------------------
package multi_pluse_sync_pkg;

  localparam int MODE_TOGGLE = 0;
  localparam int MODE_HSK    = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACK_HI = 2'd1,
    ST_DRAIN  = 2'd2
  } ch_state_t;

  // Fewer than two flops gives no metastability settling time at all.
  function automatic bit sync_stg_ok(input int stg);
    return (stg >= 2);
  endfunction

endpackage

// File: rtl/multi_pluse_sync_rx_ch.sv
// ----------------------------------------------------------------------------
// pluse_sync_ch
// One receive channel: resynchronises an asynchronous request line, detects
// source events (toggle or 4-phase handshake), emits a one-cycle pulse,
// returns an acknowledge level and counts events.
// Ports:
//   des_clk    destination clock
//   des_rst    synchronous active-high reset
//   s_req      asynchronous request / toggle line from the source domain
//   cnt_clr    synchronous clear of the event counter
//   des_pluse  registered one-cycle event pulse
//   d_ack      registered acknowledge level back to the source
//   des_busy   registered "mid-handshake" flag (always 0 in toggle mode)
//   evt_cnt    wrapping event counter
// ----------------------------------------------------------------------------
module pluse_sync_ch
  import multi_pluse_sync_pkg::*;
#(
  parameter int SYNC_STG = 2,
  parameter int MODE     = MODE_TOGGLE,
  parameter int CNT_W    = 8
) (
  input  logic             des_clk,
  input  logic             des_rst,
  input  logic             s_req,
  input  logic             cnt_clr,
  output logic             des_pluse,
  output logic             d_ack,
  output logic             des_busy,
  output logic [CNT_W-1:0] evt_cnt
);

  logic [SYNC_STG-1:0] r_sync;
  logic                w_req_s;

  logic                w_evt;
  logic                w_ack_next;
  logic                w_busy_next;

  logic                r_pluse;
  logic                r_ack;
  logic                r_busy;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_base;
  logic [CNT_W-1:0]    w_cnt_next;

  // --------------------------------------------------------------------------
  // Synchronizer chain; bit 0 is the first flop to see the foreign signal.
  // --------------------------------------------------------------------------
  always_ff @(posedge des_clk) begin
    if (des_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STG-2:0], s_req};
    end
  end

  assign w_req_s = r_sync[SYNC_STG-1];

  // --------------------------------------------------------------------------
  // Event detection per protocol
  // --------------------------------------------------------------------------
  generate
    if (MODE == MODE_HSK) begin : g_hsk
      ch_state_t r_state;
      ch_state_t w_state_next;

      // State register
      always_ff @(posedge des_clk) begin
        if (des_rst) begin
          r_state <= ST_IDLE;
        end else begin
          r_state <= w_state_next;
        end
      end

      // Next-state logic
      always_comb begin
        w_state_next = r_state;
        case (r_state)
          ST_IDLE:   if (w_req_s)  w_state_next = ST_ACK_HI;
          ST_ACK_HI: if (!w_req_s) w_state_next = ST_DRAIN;
          // Unconditional single cycle: forces at least one ack-low cycle
          // before a new request can be accepted.
          ST_DRAIN:  w_state_next = ST_IDLE;
          default:   w_state_next = ST_IDLE;
        endcase
      end

      // Output logic: next values for the registered outputs
      always_comb begin
        w_evt       = 1'b0;
        w_ack_next  = 1'b0;
        w_busy_next = 1'b0;
        case (r_state)
          ST_IDLE: begin
            if (w_req_s) begin
              w_evt       = 1'b1;
              w_ack_next  = 1'b1;
              w_busy_next = 1'b1;
            end
          end
          ST_ACK_HI: begin
            // Busy stays up through the ack-low cycle and clears on DRAIN exit.
            w_ack_next  = w_req_s;
            w_busy_next = 1'b1;
          end
          ST_DRAIN: begin
            w_ack_next  = 1'b0;
            w_busy_next = 1'b0;
          end
          default: begin
            w_ack_next  = 1'b0;
            w_busy_next = 1'b0;
          end
        endcase
      end
    end else begin : g_toggle
      // In toggle mode r_ack is exactly req_s delayed one cycle (req_d), so
      // it serves both as the edge-detect reference and as the returned ack.
      always_comb begin
        w_evt       = w_req_s ^ r_ack;
        w_ack_next  = w_req_s;
        w_busy_next = 1'b0;
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Counter: a clear coinciding with an event still counts that event.
  // --------------------------------------------------------------------------
  always_comb begin
    w_cnt_base = cnt_clr ? '0 : r_cnt;
    w_cnt_next = w_cnt_base + CNT_W'(w_evt);
  end

  // --------------------------------------------------------------------------
  // Registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge des_clk) begin
    if (des_rst) begin
      r_pluse <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_pluse <= w_evt;
      r_ack   <= w_ack_next;
      r_busy  <= w_busy_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign des_pluse = r_pluse;
  assign d_ack     = r_ack;
  assign des_busy  = r_busy;
  assign evt_cnt   = r_cnt;

endmodule

// File: rtl/multi_pluse_sync_rx.sv
// ----------------------------------------------------------------------------
// multi_pluse_sync_rx
// Receive side of a multi-channel pulse synchronizer (destination domain only).
// Ports:
//   des_clk    destination clock (only clock)
//   des_rst    synchronous active-high reset
//   s_req      [CH]        asynchronous request/toggle lines
//   cnt_clr                synchronous clear of all event counters
//   des_pluse  [CH]        one-cycle event pulses
//   d_ack      [CH]        acknowledge levels to the source domain
//   des_busy   [CH]        mid-handshake flags (4-phase mode only)
//   evt_cnt    [CH*CNT_W]  packed counters, channel i at [i*CNT_W +: CNT_W]
// ----------------------------------------------------------------------------
module multi_pluse_sync_rx
  import multi_pluse_sync_pkg::*;
#(
  parameter int CH       = 4,
  parameter int SYNC_STG = 2,
  parameter int MODE     = MODE_TOGGLE,
  parameter int CNT_W    = 8
) (
  input  logic                des_clk,
  input  logic                des_rst,
  input  logic [CH-1:0]       s_req,
  input  logic                cnt_clr,
  output logic [CH-1:0]       des_pluse,
  output logic [CH-1:0]       d_ack,
  output logic [CH-1:0]       des_busy,
  output logic [CH*CNT_W-1:0] evt_cnt
);

  generate
    if (!sync_stg_ok(SYNC_STG) || (CH < 1) || (CNT_W < 1) ||
        ((MODE != MODE_TOGGLE) && (MODE != MODE_HSK))) begin : g_bad_cfg
      $error("multi_pluse_sync_rx: illegal parameter set");
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      pluse_sync_ch #(
        .SYNC_STG (SYNC_STG),
        .MODE     (MODE),
        .CNT_W    (CNT_W)
      ) u_ch (
        .des_clk   (des_clk),
        .des_rst   (des_rst),
        .s_req     (s_req[gi]),
        .cnt_clr   (cnt_clr),
        .des_pluse (des_pluse[gi]),
        .d_ack     (d_ack[gi]),
        .des_busy  (des_busy[gi]),
        .evt_cnt   (evt_cnt[gi*CNT_W +: CNT_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_pluse_sync_rx.sv
// ----------------------------------------------------------------------------
// tb_multi_pluse_sync_rx
// Four configurations side by side:
//   dut_t : toggle mode, SYNC_STG=2, CNT_W=8
//   dut_h : 4-phase mode, SYNC_STG=2, CNT_W=8
//   dut_w : toggle mode, SYNC_STG=2, CNT_W=2 (counter wrap / clear)
//   dut_g : toggle mode, SYNC_STG=3, CNT_W=8 on a 20-unit clock, 5-unit source
// ----------------------------------------------------------------------------
module tb_multi_pluse_sync_rx;

  logic clk     = 1'b0;
  logic clk_s   = 1'b0;
  logic src_clk = 1'b0;

  always #5  clk   = ~clk;
  always #10 clk_s = ~clk_s;
  // 5-unit source clock, rising edges never aligned with clk_s edges
  initial begin
    #1;
    forever begin
      #2 src_clk = 1'b1;
      #3 src_clk = 1'b0;
    end
  end

  int checks = 0;
  int errors = 0;

  logic        rst_t = 1'b1, clr_t = 1'b0;
  logic [3:0]  req_t = '0, pl_t, ack_t, busy_t;
  logic [31:0] cnt_t;

  logic        rst_h = 1'b1, clr_h = 1'b0;
  logic [3:0]  req_h = '0, pl_h, ack_h, busy_h;
  logic [31:0] cnt_h;

  logic        rst_w = 1'b1, clr_w = 1'b0;
  logic [3:0]  req_w = '0, pl_w, ack_w, busy_w;
  logic [7:0]  cnt_w;

  logic        rst_g = 1'b1, clr_g = 1'b0;
  logic [3:0]  req_g = '0, pl_g, ack_g, busy_g;
  logic [31:0] cnt_g;

  multi_pluse_sync_rx #(.CH(4), .SYNC_STG(2), .MODE(0), .CNT_W(8)) dut_t (
    .des_clk(clk), .des_rst(rst_t), .s_req(req_t), .cnt_clr(clr_t),
    .des_pluse(pl_t), .d_ack(ack_t), .des_busy(busy_t), .evt_cnt(cnt_t));

  multi_pluse_sync_rx #(.CH(4), .SYNC_STG(2), .MODE(1), .CNT_W(8)) dut_h (
    .des_clk(clk), .des_rst(rst_h), .s_req(req_h), .cnt_clr(clr_h),
    .des_pluse(pl_h), .d_ack(ack_h), .des_busy(busy_h), .evt_cnt(cnt_h));

  multi_pluse_sync_rx #(.CH(4), .SYNC_STG(2), .MODE(0), .CNT_W(2)) dut_w (
    .des_clk(clk), .des_rst(rst_w), .s_req(req_w), .cnt_clr(clr_w),
    .des_pluse(pl_w), .d_ack(ack_w), .des_busy(busy_w), .evt_cnt(cnt_w));

  multi_pluse_sync_rx #(.CH(4), .SYNC_STG(3), .MODE(0), .CNT_W(8)) dut_g (
    .des_clk(clk_s), .des_rst(rst_g), .s_req(req_g), .cnt_clr(clr_g),
    .des_pluse(pl_g), .d_ack(ack_g), .des_busy(busy_g), .evt_cnt(cnt_g));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    repeat (6) tick();
    checks++; if ({pl_t, ack_t, busy_t, cnt_t} !== 44'h0) begin errors++;
      $display("FAIL reset_t: got %h expected 0", {pl_t, ack_t, busy_t, cnt_t}); end
    checks++; if ({pl_h, ack_h, busy_h, cnt_h} !== 44'h0) begin errors++;
      $display("FAIL reset_h: got %h expected 0", {pl_h, ack_h, busy_h, cnt_h}); end
    checks++; if ({pl_w, ack_w, busy_w, cnt_w} !== 20'h0) begin errors++;
      $display("FAIL reset_w: got %h expected 0", {pl_w, ack_w, busy_w, cnt_w}); end
    checks++; if ({pl_g, ack_g, busy_g, cnt_g} !== 44'h0) begin errors++;
      $display("FAIL reset_g: got %h expected 0", {pl_g, ack_g, busy_g, cnt_g}); end
    rst_t = 1'b0; rst_h = 1'b0; rst_w = 1'b0; rst_g = 1'b0;
    repeat (6) tick();
    checks++; if ({pl_t, pl_h, pl_w, pl_g, ack_t, ack_h} !== 24'h0) begin errors++;
      $display("FAIL post_reset_quiet: got %h expected 0", {pl_t, pl_h, pl_w, pl_g, ack_t, ack_h}); end
    $display("test_reset done");
  endtask

  // --------------------------------------------------------------------------
  task automatic test_first_toggle();
    logic [3:0] ep, ea;
    req_t[0] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      ep = (e == 3) ? 4'b0001 : 4'b0000;
      ea = (e >= 3) ? 4'b0001 : 4'b0000;
      checks++; if (pl_t !== ep) begin errors++;
        $display("FAIL first_toggle_pulse e%0d: got %b expected %b", e, pl_t, ep); end
      checks++; if (ack_t !== ea) begin errors++;
        $display("FAIL first_toggle_ack e%0d: got %b expected %b", e, ack_t, ea); end
      if (e == 3) begin
        checks++; if (cnt_t !== 32'h0000_0001) begin errors++;
          $display("FAIL first_toggle_cnt: got %h expected 00000001", cnt_t); end
      end
    end
    $display("test_first_toggle done");
  endtask

  // --------------------------------------------------------------------------
  task automatic test_all_channels();
    req_t = ~req_t;   // 0001 -> 1110: every channel toggles on the same edge
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++; if (pl_t !== ((e == 3) ? 4'b1111 : 4'b0000)) begin errors++;
        $display("FAIL all_ch_pulse e%0d: got %b expected %b", e, pl_t, (e == 3) ? 4'b1111 : 4'b0000); end
    end
    checks++; if (cnt_t !== 32'h0101_0102) begin errors++;
      $display("FAIL all_ch_cnt: got %h expected 01010102", cnt_t); end
    checks++; if (ack_t !== 4'b1110) begin errors++;
      $display("FAIL all_ch_ack: got %b expected 1110", ack_t); end
    $display("test_all_channels done");
  endtask

  // --------------------------------------------------------------------------
  // 4-phase on channel 1: drop after ack seen, re-raise so the synchronized
  // request is already high during DRAIN; the second event must not be lost.
  task automatic test_handshake();
    int ep[10] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    int ea[10] = '{0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
    int eb[10] = '{0, 0, 1, 1, 1, 1, 1, 0, 1, 1};
    req_h[1] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++; if (pl_h !== (4'(ep[e-1]) << 1)) begin errors++;
        $display("FAIL hsk_pulse e%0d: got %b expected %b", e, pl_h, 4'(ep[e-1]) << 1); end
      checks++; if (ack_h !== (4'(ea[e-1]) << 1)) begin errors++;
        $display("FAIL hsk_ack e%0d: got %b expected %b", e, ack_h, 4'(ea[e-1]) << 1); end
      checks++; if (busy_h !== (4'(eb[e-1]) << 1)) begin errors++;
        $display("FAIL hsk_busy e%0d: got %b expected %b", e, busy_h, 4'(eb[e-1]) << 1); end
      if (e == 4) req_h[1] = 1'b0;
      if (e == 5) req_h[1] = 1'b1;
    end
    checks++; if (cnt_h !== 32'h0000_0200) begin errors++;
      $display("FAIL hsk_cnt: got %h expected 00000200", cnt_h); end
    req_h[1] = 1'b0;
    repeat (6) tick();
    checks++; if ({ack_h, busy_h} !== 8'h0) begin errors++;
      $display("FAIL hsk_idle: got %h expected 00", {ack_h, busy_h}); end
    $display("test_handshake done");
  endtask

  // --------------------------------------------------------------------------
  // Randomized 4-phase transactions: each full handshake is one event.
  task automatic test_handshake_random();
    int cnt_m[4] = '{0, 2, 0, 0};
    int ch, hold, pulses, waited;
    for (int k = 0; k < 10; k++) begin
      ch = $urandom_range(0, 3);
      hold = $urandom_range(0, 5);
      pulses = 0;
      req_h[ch] = 1'b1;
      waited = 0;
      while (ack_h[ch] !== 1'b1 && waited < 20) begin
        tick(); pulses += int'(pl_h[ch]); waited++;
      end
      checks++; if (ack_h[ch] !== 1'b1) begin errors++;
        $display("FAIL hsk_rand_ack_rise ch%0d: got %b expected 1", ch, ack_h[ch]); end
      repeat (hold) begin tick(); pulses += int'(pl_h[ch]); end
      req_h[ch] = 1'b0;
      waited = 0;
      while ((ack_h[ch] !== 1'b0 || busy_h[ch] !== 1'b0) && waited < 20) begin
        tick(); pulses += int'(pl_h[ch]); waited++;
      end
      checks++; if ({ack_h[ch], busy_h[ch]} !== 2'b00) begin errors++;
        $display("FAIL hsk_rand_release ch%0d: got %b expected 00", ch, {ack_h[ch], busy_h[ch]}); end
      cnt_m[ch]++;
      checks++; if (pulses != 1) begin errors++;
        $display("FAIL hsk_rand_pulses ch%0d: got %0d expected 1", ch, pulses); end
      checks++; if (cnt_h[ch*8 +: 8] !== 8'(cnt_m[ch])) begin errors++;
        $display("FAIL hsk_rand_cnt ch%0d: got %0d expected %0d", ch, cnt_h[ch*8 +: 8], cnt_m[ch]); end
      $display("hsk txn %0d ch%0d hold=%0d pulses=%0d", k, ch, hold, pulses);
    end
    $display("test_handshake_random done");
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_midop();
    req_h[2] = 1'b1;
    repeat (3) tick();
    checks++; if (ack_h !== 4'b0100) begin errors++;
      $display("FAIL midrst_ack_before: got %b expected 0100", ack_h); end
    rst_h = 1'b1;
    tick();
    checks++; if ({pl_h, ack_h, busy_h} !== 12'h0) begin errors++;
      $display("FAIL midrst_outputs: got %h expected 000", {pl_h, ack_h, busy_h}); end
    checks++; if (cnt_h !== 32'h0) begin errors++;
      $display("FAIL midrst_cnt: got %h expected 0", cnt_h); end
    tick();
    rst_h = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++; if (pl_h !== ((e == 3) ? 4'b0100 : 4'b0000)) begin errors++;
        $display("FAIL midrst_pulse e%0d: got %b expected %b", e, pl_h, (e == 3) ? 4'b0100 : 4'b0000); end
    end
    checks++; if (cnt_h !== 32'h0001_0000) begin errors++;
      $display("FAIL midrst_cnt_after: got %h expected 00010000", cnt_h); end
    req_h[2] = 1'b0;
    repeat (8) tick();
    $display("test_reset_midop done");
  endtask

  // --------------------------------------------------------------------------
  task automatic test_wrap_clear();
    logic [1:0] exp_c;
    for (int k = 1; k <= 5; k++) begin
      req_w[2] = ~req_w[2];
      exp_c = 2'(k % 4);
      for (int e = 1; e <= 4; e++) begin
        tick();
        checks++; if (pl_w !== ((e == 3) ? 4'b0100 : 4'b0000)) begin errors++;
          $display("FAIL wrap_pulse k%0d e%0d: got %b", k, e, pl_w); end
      end
      checks++; if (cnt_w !== {2'b00, exp_c, 4'b0000}) begin errors++;
        $display("FAIL wrap_cnt k%0d: got %h expected %h", k, cnt_w, {2'b00, exp_c, 4'b0000}); end
      $display("wrap event %0d cnt2=%0d", k, cnt_w[5:4]);
    end
    req_w[2] = ~req_w[2];
    tick(); tick();
    clr_w = 1'b1;      // sampled on the same edge the 6th pulse asserts
    tick();
    clr_w = 1'b0;
    checks++; if ({pl_w, cnt_w} !== {4'b0100, 8'h10}) begin errors++;
      $display("FAIL clr_with_event: got %h expected 410", {pl_w, cnt_w}); end
    clr_w = 1'b1;
    tick();
    clr_w = 1'b0;
    checks++; if (cnt_w !== 8'h00) begin errors++;
      $display("FAIL clr_alone: got %h expected 00", cnt_w); end
    $display("test_wrap_clear done");
  endtask

  // --------------------------------------------------------------------------
  // Delay-line model: sampled input history; pulse after edge n is the change
  // between the samples taken SYNC_STG and SYNC_STG+1 edges earlier.
  task automatic test_random_toggle();
    logic [3:0]  hist[$];
    logic [3:0]  e_pl, e_ack;
    logic [31:0] e_cnt;
    logic        clr_now;
    int          L;
    req_t = '0; clr_t = 1'b0; rst_t = 1'b1;
    repeat (2) tick();
    rst_t = 1'b0;
    e_cnt = '0;
    hist = '{4'h0, 4'h0, 4'h0};
    for (int n = 0; n < 400; n++) begin
      clr_now = clr_t;
      hist.push_back(req_t);
      tick();
      L = hist.size() - 1;
      e_ack = hist[L-2];
      e_pl  = hist[L-2] ^ hist[L-3];
      for (int c = 0; c < 4; c++) begin
        if (clr_now) e_cnt[c*8 +: 8] = 8'(e_pl[c]);
        else         e_cnt[c*8 +: 8] = e_cnt[c*8 +: 8] + 8'(e_pl[c]);
      end
      checks++; if (pl_t !== e_pl) begin errors++;
        $display("FAIL rand_pulse n%0d: got %b expected %b", n, pl_t, e_pl); end
      checks++; if ({ack_t, busy_t} !== {e_ack, 4'b0000}) begin errors++;
        $display("FAIL rand_ack n%0d: got %b expected %b", n, {ack_t, busy_t}, {e_ack, 4'b0000}); end
      checks++; if (cnt_t !== e_cnt) begin errors++;
        $display("FAIL rand_cnt n%0d: got %h expected %h", n, cnt_t, e_cnt); end
      // Source rule: toggle again only once the ack matches the line.
      for (int c = 0; c < 4; c++) begin
        if (req_t[c] == e_ack[c] && $urandom_range(0, 3) == 0) req_t[c] = ~req_t[c];
      end
      clr_t = ($urandom_range(0, 31) == 0);
    end
    clr_t = 1'b0;
    $display("test_random_toggle done cnt=%h", cnt_t);
  endtask

  // --------------------------------------------------------------------------
  // SYNC_STG=3 on a 20-unit clock; two toggles 16 source periods apart.
  task automatic test_sync3();
    int pulses = 0;
    fork
      begin
        @(posedge src_clk);
        req_g[0] = 1'b1;
        repeat (16) @(posedge src_clk);
        req_g[0] = 1'b0;
      end
      begin
        logic [3:0] hist[$];
        logic [3:0] e_pl;
        int         L;
        hist = '{4'h0, 4'h0, 4'h0, 4'h0};
        for (int n = 0; n < 16; n++) begin
          @(posedge clk_s);
          hist.push_back(req_g);
          #1;
          L = hist.size() - 1;
          e_pl = hist[L-3] ^ hist[L-4];
          checks++; if (pl_g !== e_pl) begin errors++;
            $display("FAIL sync3_pulse n%0d: got %b expected %b", n, pl_g, e_pl); end
          pulses += int'(pl_g[0]);
        end
      end
    join
    checks++; if (pulses != 2) begin errors++;
      $display("FAIL sync3_count: got %0d expected 2", pulses); end
    checks++; if (cnt_g !== 32'h0000_0002) begin errors++;
      $display("FAIL sync3_cnt: got %h expected 00000002", cnt_g); end
    $display("test_sync3 done pulses=%0d", pulses);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_toggle();
    test_all_channels();
    test_handshake();
    test_handshake_random();
    test_reset_midop();
    test_wrap_clear();
    test_random_toggle();
    test_sync3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
